mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-ported, variable-latency memory between the fetch stage (instruction reads) and the mem stage (data loads/stores) of the 5-stage MIPS core. A 3-state FSM grants one requester at a time and registers the request onto the memory port. It holds the request until the memory acknowledges, then returns read data to the winner. Per-requester stall flags let the pipeline freeze while its access is outstanding.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width
TIMEOUT_CYCLES, 255, wait-state limit before abort (used only with MEM_ARB_TIMEOUT_EN)

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_if_req  input  1  fetch read request; held with i_if_addr until o_if_ack
i_if_addr  input  ADDR_W  fetch address
o_if_ack  output  1  one-cycle pulse: fetch access complete
o_if_rdata  output  DATA_W  instruction word; valid only while o_if_ack=1, else 0
i_d_req  input  1  data request; held with addr/we/wdata until o_d_ack
i_d_we  input  1  1=store, 0=load
i_d_addr  input  ADDR_W  data address
i_d_wdata  input  DATA_W  store data
o_d_ack  output  1  one-cycle pulse: data access complete
o_d_rdata  output  DATA_W  load data; valid only while o_d_ack=1, else 0
o_mem_req  output  1  memory request, registered
o_mem_we  output  1  memory write enable, registered
o_mem_addr  output  ADDR_W  memory address, registered
o_mem_wdata  output  DATA_W  memory write data, registered
i_mem_ack  input  1  memory completion pulse; i_mem_rdata valid in same cycle
i_mem_rdata  input  DATA_W  memory read data
o_con_stall_if  output  1  i_if_req & ~o_if_ack
o_con_stall_mem  output  1  i_d_req & ~o_d_ack
o_con_err  output  1  sticky timeout error

Behaviour:
- Reset (async, active-low): state=IDLE; o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_con_err all 0; wait counter 0. Resetting mid-access abandons it: o_mem_req falls immediately and no ack is issued.
- States: IDLE, IF_WAIT, D_WAIT.
- IDLE arbitration: data has fixed priority because it belongs to the older instruction.
  - i_d_req=1: go to D_WAIT; latch d_addr/we/wdata into o_mem_*; o_mem_req=1 from the next cycle.
  - Otherwise i_if_req=1: go to IF_WAIT; latch if_addr; o_mem_we=0.
  - Neither: stay in IDLE.
- *_WAIT: o_mem_* held stable. On i_mem_ack=1, the granted requester's ack pulses combinationally in the same cycle, with rdata = i_mem_rdata.
- Ack-cycle re-arbitration (fairness): the just-served requester is excluded.
  - D_WAIT ack with i_if_req=1: go to IF_WAIT, load fetch address, o_mem_req stays 1 (back-to-back, no bubble).
  - IF_WAIT ack with i_d_req=1: go to D_WAIT likewise.
  - Otherwise: go to IDLE, o_mem_req=0.
- Best-case latency: request sampled in cycle N, o_mem_req high in N+1, ack in N+1 with zero-wait memory. The requester sees a 2-cycle access.
- i_mem_ack in IDLE: ignored, no ack issued.
- Requester drops req before its ack (protocol violation): the access still completes on memory; the ack pulse is suppressed.
- Stores: o_d_ack pulses; o_d_rdata = i_mem_rdata (ignored by mem stage).
- Never more than one outstanding memory request.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined: an 8..16-bit counter clears on entry to *_WAIT and increments each wait cycle without i_mem_ack. On reaching TIMEOUT_CYCLES, the FSM aborts: o_mem_req=0, the granted requester's ack pulses with rdata=0, o_con_err sets (sticky until reset), and state returns to IDLE.
- Undefined: no counter; the FSM waits indefinitely; o_con_err is tied to 0.

Test Plan:
- Fetch only: i_if_req=1, addr=0x0000_0040, memory acks 3 cycles after o_mem_req with 0x2008_0005 -> o_mem_addr=0x40, o_mem_we=0, single o_if_ack with o_if_rdata=0x2008_0005, o_con_stall_if high until that cycle.
- Simultaneous: both reqs in the same IDLE cycle; data store addr=0x100, wdata=0xCAFE_F00D -> D_WAIT first with o_mem_we=1. On ack, IF_WAIT next with o_mem_req continuously high. Acks ordered d then if.
- Back-to-back fairness: i_d_req held for 3 consecutive loads while i_if_req=1 -> grants alternate D, IF, D, IF, D; fetch never waits more than one data access.
- Spurious ack: i_mem_ack=1 in IDLE -> no o_if_ack/o_d_ack, state unchanged.
- Reset mid-access: assert i_rst_n=0 during D_WAIT -> o_mem_req=0 asynchronously, no ack. After release with i_if_req=1, a normal fetch completes.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: memory never acks -> o_mem_req drops after 8 wait cycles, o_if_ack pulses with rdata=0, o_con_err=1 and stays 1; without the macro, o_mem_req stays high and o_con_err=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, variable-latency memory between the
// fetch stage (instruction reads) and the mem stage (data loads/stores).
//
// Data has fixed priority in IDLE (it belongs to the older instruction). On a
// completing access the other requester is served next without a bubble, so
// fetch never waits behind more than one data access.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_if_req/i_if_addr        fetch read request (held until o_if_ack)
//   o_if_ack/o_if_rdata       fetch completion pulse and instruction word
//   i_d_req/i_d_we/i_d_addr/i_d_wdata   data request (held until o_d_ack)
//   o_d_ack/o_d_rdata         data completion pulse and load data
//   o_mem_req/we/addr/wdata   registered memory request
//   i_mem_ack/i_mem_rdata     memory completion pulse and read data
//   o_con_stall_if/mem        pipeline stall flags
//   o_con_err                 sticky timeout error
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES wait cycles without i_mem_ack. Undefined: wait forever,
// o_con_err tied to 0.
module mem_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_con_stall_if,
  output logic              o_con_stall_mem,
  output logic              o_con_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    D_WAIT  = 2'd2
  } state_t;

  state_t              state_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic in_wait;
  logic abort;
  logic done;

  assign in_wait = (state_q == IF_WAIT) || (state_q == D_WAIT);

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt_q;
  logic [15:0] wait_cnt_d;
  logic        err_q;

  // Abort in the wait cycle that would bring the count to TIMEOUT_CYCLES.
  assign abort = in_wait && !i_mem_ack &&
                 (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Cleared in IDLE and on every completion, so each new grant starts at 0.
  always_comb begin
    wait_cnt_d = '0;
    if (in_wait && !done) wait_cnt_d = wait_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (abort) err_q <= 1'b1;
    end
  end

  assign o_con_err = err_q;
`else
  // The limit is meaningless without the counter.
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
  assign abort     = 1'b0;
  assign o_con_err = 1'b0;
`endif

  assign done = in_wait && (i_mem_ack || abort);

  // Acks are suppressed if the requester has already withdrawn its request.
  assign o_if_ack   = (state_q == IF_WAIT) && (i_mem_ack || abort) && i_if_req;
  assign o_d_ack    = (state_q == D_WAIT)  && (i_mem_ack || abort) && i_d_req;
  assign o_if_rdata = (o_if_ack && !abort) ? i_mem_rdata : '0;
  assign o_d_rdata  = (o_d_ack  && !abort) ? i_mem_rdata : '0;

  assign o_con_stall_if  = i_if_req && !o_if_ack;
  assign o_con_stall_mem = i_d_req  && !o_d_ack;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_d_req) begin
            state_q     <= D_WAIT;
            mem_req_q   <= 1'b1;
            mem_we_q    <= i_d_we;
            mem_addr_q  <= i_d_addr;
            mem_wdata_q <= i_d_wdata;
          end else if (i_if_req) begin
            state_q    <= IF_WAIT;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= i_if_addr;
          end
        end
        IF_WAIT: begin
          if (done) begin
            // Hand over to data without dropping o_mem_req; an abort never
            // re-arbitrates.
            if (i_mem_ack && i_d_req) begin
              state_q     <= D_WAIT;
              mem_we_q    <= i_d_we;
              mem_addr_q  <= i_d_addr;
              mem_wdata_q <= i_d_wdata;
            end else begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
            end
          end
        end
        D_WAIT: begin
          if (done) begin
            if (i_mem_ack && i_if_req) begin
              state_q    <= IF_WAIT;
              mem_we_q   <= 1'b0;
              mem_addr_q <= i_if_addr;
            end else begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with hand-computed expected values.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          stall_if;
  logic          stall_mem;
  logic          con_err;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(8)
  ) u_dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_if_req(if_req),
    .i_if_addr(if_addr),
    .o_if_ack(if_ack),
    .o_if_rdata(if_rdata),
    .i_d_req(d_req),
    .i_d_we(d_we),
    .i_d_addr(d_addr),
    .i_d_wdata(d_wdata),
    .o_d_ack(d_ack),
    .o_d_rdata(d_rdata),
    .o_mem_req(mem_req),
    .o_mem_we(mem_we),
    .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack),
    .i_mem_rdata(mem_rdata),
    .o_con_stall_if(stall_if),
    .o_con_stall_mem(stall_mem),
    .o_con_err(con_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Lands 1 time unit after the rising edge; checks follow a further #1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

    // Reset state
    #12;
    check("rst_mem_req",   64'(mem_req),   64'd0);
    check("rst_mem_we",    64'(mem_we),    64'd0);
    check("rst_mem_addr",  64'(mem_addr),  64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_err",       64'(con_err),   64'd0);
    check("rst_acks",      64'({if_ack, d_ack, stall_if, stall_mem}), 64'd0);
    #10 rst_n = 1'b1;

    // Fetch only: three wait cycles, then ack
    tick();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    #1;
    check("f_stall_idle", 64'(stall_if), 64'd1);
    check("f_req_idle",   64'(mem_req),  64'd0);
    tick(); #1;
    check("f_mem_req",  64'(mem_req),  64'd1);
    check("f_mem_addr", 64'(mem_addr), 64'h40);
    check("f_mem_we",   64'(mem_we),   64'd0);
    check("f_noack0",   64'(if_ack),   64'd0);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      check("f_wait_req",   64'(mem_req),  64'd1);
      check("f_wait_stall", 64'({if_ack, stall_if}), 64'b01);
    end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
    #1;
    check("f_ack",      64'(if_ack),   64'd1);
    check("f_rdata",    64'(if_rdata), 64'h2008_0005);
    check("f_stall_lo", 64'(stall_if), 64'd0);
    check("f_no_dack",  64'(d_ack),    64'd0);
    tick();
    if_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    #1;
    check("f_idle_req",   64'(mem_req),  64'd0);
    check("f_rdata_zero", 64'({if_ack, if_rdata}), 64'd0);

    // Simultaneous: store wins, fetch follows with no bubble
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D;
    if_req = 1'b1; if_addr = 32'h44;
    #1;
    check("s_stalls", 64'({stall_if, stall_mem}), 64'b11);
    tick(); #1;
    check("s_req",   64'(mem_req),   64'd1);
    check("s_we",    64'(mem_we),    64'd1);
    check("s_addr",  64'(mem_addr),  64'h100);
    check("s_wdata", 64'(mem_wdata), 64'hCAFE_F00D);
    mem_ack = 1'b1; mem_rdata = 32'h0000_1234;
    #1;
    check("s_dack",     64'({d_ack, if_ack}), 64'b10);
    check("s_drdata",   64'(d_rdata), 64'h1234);
    tick();
    d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    #1;
    check("s_b2b_req",  64'(mem_req),  64'd1);
    check("s_if_addr",  64'(mem_addr), 64'h44);
    check("s_if_we",    64'(mem_we),   64'd0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
    #1;
    check("s_ifack",   64'({d_ack, if_ack}), 64'b01);
    check("s_ifrdata", 64'(if_rdata), 64'hAAAA_5555);
    tick();
    if_req = 1'b0; mem_ack = 1'b0;
    #1;
    check("s_idle", 64'(mem_req), 64'd0);

    // Back-to-back fairness: D, IF, D, IF, D with zero-wait memory
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h300;
    tick();
    for (int g = 0; g < 5; g++) begin
      logic exp_d;
      exp_d = (g % 2 == 0);
      #1;
      check("fair_req",  64'(mem_req),  64'd1);
      check("fair_addr", 64'(mem_addr), exp_d ? 64'h200 : 64'h300);
      mem_ack = 1'b1; mem_rdata = 32'(g + 1);
      #1;
      check("fair_acks", 64'({d_ack, if_ack}), exp_d ? 64'b10 : 64'b01);
      check("fair_rdata", 64'(exp_d ? d_rdata : if_rdata), 64'(g + 1));
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (g == 3) if_req = 1'b0;
      if (g == 4) d_req = 1'b0;
    end
    #1;
    check("fair_idle", 64'(mem_req), 64'd0);

    // Spurious ack in IDLE
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("sp_acks",  64'({if_ack, d_ack}), 64'd0);
    check("sp_rdata", 64'({if_rdata, d_rdata}), 64'd0);
    tick();
    mem_ack = 1'b0;
    #1;
    check("sp_req", 64'(mem_req), 64'd0);

    // Reset mid-access abandons the store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h1111_2222;
    tick(); #1;
    check("r_req_before", 64'(mem_req), 64'd1);
    #1 rst_n = 1'b0; mem_ack = 1'b1;
    #1;
    check("r_req_async", 64'(mem_req), 64'd0);
    check("r_no_ack",    64'(d_ack),   64'd0);
    d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    #3 rst_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h80;
    tick(); #1;
    check("r_f_req",  64'(mem_req),  64'd1);
    check("r_f_addr", 64'(mem_addr), 64'h80);
    check("r_f_we",   64'(mem_we),   64'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_BEEF;
    #1;
    check("r_f_ack", 64'({if_ack, if_rdata}), {1'b1, 32'h0BAD_BEEF});
    tick();
    if_req = 1'b0; mem_ack = 1'b0;

    // Requester withdraws before ack: access completes, ack suppressed
    if_req = 1'b1; if_addr = 32'h90;
    tick();
    if_req = 1'b0;
    tick(); #1;
    check("w_req_held", 64'(mem_req), 64'd1);
    mem_ack = 1'b1; mem_rdata = 32'h5A5A_5A5A;
    #1;
    check("w_no_ack", 64'({if_ack, if_rdata}), 64'd0);
    tick();
    mem_ack = 1'b0;
    #1;
    check("w_idle", 64'(mem_req), 64'd0);

    // Memory never acks
    if_req = 1'b1; if_addr = 32'hA0;
    tick();
`ifdef MEM_ARB_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      #1;
      check("t_wait", 64'({mem_req, if_ack}), 64'b10);
      tick();
    end
    #1;
    check("t_abort_ack", 64'({if_ack, if_rdata}), {1'b1, 32'h0});
    tick();
    if_req = 1'b0;
    #1;
    check("t_req_drop", 64'(mem_req), 64'd0);
    check("t_err",      64'(con_err), 64'd1);
    tick(); tick(); #1;
    check("t_err_sticky", 64'(con_err), 64'd1);
`else
    for (int k = 0; k < 20; k++) tick();
    #1;
    check("t_req_held", 64'(mem_req), 64'd1);
    check("t_no_err",   64'({con_err, if_ack}), 64'd0);
    mem_ack = 1'b1; mem_rdata = 32'h7777_0000;
    #1;
    check("t_late_ack", 64'({if_ack, if_rdata}), {1'b1, 32'h7777_0000});
    tick();
    if_req = 1'b0; mem_ack = 1'b0;
    #1;
    check("t_idle", 64'(mem_req), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
